tlcd_cgram_loader: RTL
======================

# tlcd_cgram_loader

Parametrised CGRAM glyph loader for the HD44780-class text LCD. It holds up to eight 5x8 user glyphs in a runtime-writable store. On each START it streams one Set-CGRAM-address command followed by every glyph row to the panel, with a generated E strobe of programmable width and spacing. It sits between user logic and the TLCD pins, ahead of the text writer, and reports BUSY/DONE so the text writer can sequence after it.

## Interface
- NUM_GLYPHS, 5: glyphs stored and sent, legal range 1..8.
- E_HIGH_CYC, 1: CLK cycles E is held high per transfer, minimum 1.
- CMD_WAIT_CYC, 2: CLK cycles E is held low after the pulse with the bus held, minimum 1.
- CLK  in  1  system clock; all logic on rising edge.
- RESETN  in  1  synchronous, active-high reset; name kept per codebase.
- START  in  1  request a full load; sampled in IDLE only.
- GLYPH_WE  in  1  glyph-store write strobe.
- GLYPH_WADDR  in  6  {glyph[2:0], row[2:0]}.
- GLYPH_WDATA  in  5  row pixels, bit 4 = leftmost pixel.
- BUSY  out  1  high while a load is in progress.
- DONE  out  1  one-cycle pulse when a load completes.
- TLCD_E  out  1  LCD enable strobe.
- TLCD_RS  out  1  0 = command, 1 = data.
- TLCD_RW  out  1  always 0 (write only).
- TLCD_DATA  out  8  LCD data bus.
- STATE  out  3  current FSM state, for debug.

## Operation
- Glyph store: NUM_GLYPHS*8 x 5 bits, cleared to 0 by reset.
  - Writes are accepted in any state.
  - Writes with glyph >= NUM_GLYPHS are ignored.
  - A write to a row not yet transmitted in the current load appears in this load. Otherwise it appears in the next load.
- Transfer sequence, N = NUM_GLYPHS*8 data bytes:
  - Transfer 0: RS=0, DATA=0x40.
  - Transfers 1..N: RS=1, DATA={3'b000, row}, glyph-major, row 0 first.
  - The panel auto-increments the address; no per-glyph address command is sent.
- FSM states, encoding in STATE:
  - IDLE=0: START -> SETUP.
  - SETUP=1: one cycle; RS/DATA driven, E=0 -> PULSE.
  - PULSE=2: E=1 for E_HIGH_CYC cycles -> WAIT.
  - WAIT=3: E=0 with bus held for CMD_WAIT_CYC cycles -> SETUP for the next transfer, else DONE.
  - DONE=4: one cycle, DONE=1 -> IDLE.
  - Encodings 5..7 -> IDLE.
- BUSY=1 exactly in SETUP, PULSE and WAIT.
- START while BUSY or in DONE is ignored and not queued.
- TLCD_DATA, TLCD_RS and TLCD_RW only change in the cycle entering SETUP, so they are stable across the whole E-high window.
- Reset, including mid-transfer: all outputs go to reset values at the same edge and the load is aborted. No partial resume.

## Timing
- Reset values:
  - TLCD_E=0, TLCD_RS=0, TLCD_RW=0, TLCD_DATA=0x00.
  - BUSY=0, DONE=0, STATE=0.
- Transfer period T = 1 + E_HIGH_CYC + CMD_WAIT_CYC.
- START sampled at edge k: SETUP is in cycle k+1, and E is high in cycles k+2..k+1+E_HIGH_CYC.
- With M transfers, DONE is high in cycle k + M*T + 1. BUSY is high for M*T cycles.
- Defaults (T=4, M=41): DONE at k+165.
- The counter that selects the next byte is sized for 0..64.

## Configuration
- TLCD_CGRAM_HOME_EN defined:
  - After the last data byte, one extra command transfer is sent: RS=0, DATA=0x80 (Set DDRAM address 0).
  - M = N+2, so the panel address counter is left in DDRAM at the home position.
- Macro undefined: M = N+1, and the address counter is left in CGRAM.

## Structure
- Package tlcd_pkg holds:
  - State encodings.
  - CMD_SET_CGRAM=8'h40 and CMD_SET_DDRAM=8'h80.
  - GLYPH_ROWS=8 and GLYPH_W=5.
- Sub-module tlcd_strobe generates one transfer's SETUP/PULSE/WAIT timing with E_HIGH_CYC and CMD_WAIT_CYC.
  - It uses a go/ack handshake: go is accepted when idle, and ack is a one-cycle pulse at the end of WAIT.
  - The loader FSM and byte counter drive it.

## Test plan
- Defaults, reset, then START at edge 0:
  - Transfer 0 is RS=0, DATA=0x40; 40 data bytes of 0x00 follow.
  - 41 E pulses of 1 cycle each.
  - DONE at cycle 165; BUSY high 164 cycles.
- Write GLYPH_WADDR=6'o11, GLYPH_WDATA=5'b10101, then START: transfer 10 is RS=1, DATA=0x15; all other data bytes are 0x00.
- START pulsed again at cycle 50 of a load: ignored; a single DONE at 165; no extra E pulses.
- RESETN asserted while STATE=PULSE: next cycle E=0, STATE=0, DATA=0x00, BUSY=0. A following START runs a full 165-cycle load.
- NUM_GLYPHS=5, write glyph 6 (addr 6'o60, data 5'h1F): ignored. Write glyph 0 row 0 during transfer 20: absent from this load, present as transfer 1 of the next load.
- TLCD_CGRAM_HOME_EN defined, defaults: 42 transfers, last transfer RS=0, DATA=0x80, DONE at cycle 169.

Source files
------------

// File: rtl/tlcd_pkg.sv
// Shared definitions for the TLCD CGRAM glyph loader: FSM state encodings
// (as seen on the STATE debug port), LCD command bytes and glyph geometry.
package tlcd_pkg;

  // Encodings visible on STATE; the strobe reuses IDLE..WAIT for its phase.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Loader sequencing: RUN covers SETUP/PULSE/WAIT, which the strobe details.
  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_RUN  = 2'd1,
    CTL_DONE = 2'd2
  } ctl_e;

  localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam int         GLYPH_ROWS    = 8;
  localparam int         GLYPH_W       = 5;

endpackage

// File: rtl/tlcd_strobe.sv
// One-transfer E strobe timing: SETUP (1 cycle), PULSE (E high for
// E_HIGH_CYC cycles), WAIT (E low for CMD_WAIT_CYC cycles).
// Handshake: go is accepted while idle or in the final WAIT cycle (when ack
// is high), which lets transfers run back to back with no gap. ack is high
// for exactly one cycle, the last cycle of WAIT.
module tlcd_strobe
  import tlcd_pkg::*;
#(
  parameter int E_HIGH_CYC   = 1,
  parameter int CMD_WAIT_CYC = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   go,
  output logic   e,
  output logic   ack,
  output state_e phase
);

  logic [15:0] cnt;

  assign ack = (phase == ST_WAIT) && (cnt == 16'(CMD_WAIT_CYC - 1));

  // Phase sequencer with registered E.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= ST_IDLE;
      e     <= 1'b0;
      cnt   <= '0;
    end else begin
      case (phase)
        ST_IDLE: begin
          if (go) phase <= ST_SETUP;
        end
        ST_SETUP: begin
          phase <= ST_PULSE;
          e     <= 1'b1;
          cnt   <= '0;
        end
        ST_PULSE: begin
          if (cnt == 16'(E_HIGH_CYC - 1)) begin
            phase <= ST_WAIT;
            e     <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT: begin
          if (ack) phase <= go ? ST_SETUP : ST_IDLE;
          else     cnt   <= cnt + 16'd1;
        end
        default: begin
          phase <= ST_IDLE;
          e     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tlcd_cgram_loader.sv
// CGRAM glyph loader for HD44780-class text LCDs. Holds NUM_GLYPHS 5x8
// glyphs and, on START, sends Set-CGRAM-address 0 followed by every glyph
// row, glyph-major. Optional macro TLCD_CGRAM_HOME_EN appends a
// Set-DDRAM-address 0 command so the panel is left at the home position.
// Bus (RS/DATA) only changes on the edge that enters SETUP, so it is stable
// across the whole E-high window.
module tlcd_cgram_loader
  import tlcd_pkg::*;
#(
  parameter int NUM_GLYPHS   = 5,
  parameter int E_HIGH_CYC   = 1,
  parameter int CMD_WAIT_CYC = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic       GLYPH_WE,
  input  logic [5:0] GLYPH_WADDR,
  input  logic [4:0] GLYPH_WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA,
  output logic [2:0] STATE
);

  localparam int N = NUM_GLYPHS * GLYPH_ROWS;
`ifdef TLCD_CGRAM_HOME_EN
  localparam int M = N + 2;
`else
  localparam int M = N + 1;
`endif

  ctl_e               ctl;
  logic [6:0]         idx;
  logic [6:0]         sel_idx;
  logic               sel_rs;
  logic [7:0]         sel_data;
  logic               go;
  logic               ack;
  state_e             phase;
  logic [GLYPH_W-1:0] mem [64];

  // Glyph store: writes to glyphs beyond NUM_GLYPHS are dropped.
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (GLYPH_WE && ({1'b0, GLYPH_WADDR[5:3]} < 4'(NUM_GLYPHS))) begin
      mem[GLYPH_WADDR] <= GLYPH_WDATA;
    end
  end

  // Byte for the transfer about to enter SETUP.
  always_comb begin
    sel_idx  = (ctl == CTL_IDLE) ? 7'd0 : idx + 7'd1;
    sel_rs   = 1'b0;
    sel_data = CMD_SET_CGRAM;
    if (sel_idx != 7'd0) begin
      if (sel_idx <= 7'(N)) begin
        sel_rs   = 1'b1;
        sel_data = {3'b000, mem[6'(sel_idx - 7'd1)]};
      end else begin
`ifdef TLCD_CGRAM_HOME_EN
        sel_rs   = 1'b0;
        sel_data = CMD_SET_DDRAM;
`endif
      end
    end
  end

  assign go = ((ctl == CTL_IDLE) && START) ||
              ((ctl == CTL_RUN) && ack && (idx != 7'(M - 1)));

  // Loader FSM: owns the byte counter, the bus registers and DONE.
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      ctl       <= CTL_IDLE;
      idx       <= '0;
      TLCD_RS   <= 1'b0;
      TLCD_DATA <= 8'h00;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (ctl)
        CTL_IDLE: begin
          if (START) begin
            ctl       <= CTL_RUN;
            idx       <= '0;
            TLCD_RS   <= sel_rs;
            TLCD_DATA <= sel_data;
          end
        end
        CTL_RUN: begin
          if (ack) begin
            if (idx == 7'(M - 1)) begin
              ctl  <= CTL_DONE;
              DONE <= 1'b1;
            end else begin
              idx       <= idx + 7'd1;
              TLCD_RS   <= sel_rs;
              TLCD_DATA <= sel_data;
            end
          end
        end
        CTL_DONE: ctl <= CTL_IDLE;
        default:  ctl <= CTL_IDLE;
      endcase
    end
  end

  tlcd_strobe #(
    .E_HIGH_CYC  (E_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC)
  ) u_strobe (
    .clk  (CLK),
    .rst  (RESETN),
    .go   (go),
    .e    (TLCD_E),
    .ack  (ack),
    .phase(phase)
  );

  assign BUSY    = (ctl == CTL_RUN);
  assign TLCD_RW = 1'b0;

  // Debug state: strobe phase while running, otherwise loader state.
  always_comb begin
    case (ctl)
      CTL_RUN:  STATE = phase;
      CTL_DONE: STATE = ST_DONE;
      default:  STATE = ST_IDLE;
    endcase
  end

endmodule
